seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the board's single 4-digit hex seven-segment scanner between NUM_SRC requesters, e.g. PC, ALU result, register read port and memory data.
- Selects one valid source and drives its 16-bit value onto the scanner's q_a input.
- Rotates between valid sources automatically after a dwell time, or on a debounced button pulse.
- Sits between the CPU debug taps and the seven-segment scanner module.

Parameters:
- NUM_SRC, 4: number of requesters. Legal range 2..8.
- SEL_W, 2: width of src_sel. Must equal clog2(NUM_SRC).
- DWELL_CYCLES, 50_000_000: clk cycles each source is shown in auto mode. Minimum 2.
- CNT_W, 26: dwell counter width. Must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- src_valid  in  NUM_SRC  bit i high means source i has data to show.
- src_data  in  16*NUM_SRC  source i occupies bits [16*i+15:16*i].
- btn_next  in  1  single-cycle pulse, already debounced; advances to the next valid source.
- auto_en  in  1  1 enables dwell-based rotation; 0 holds the current source.
- q_a  out  16  value to the scanner, registered.
- src_sel  out  SEL_W  index of the displayed source, registered.
- grant  out  NUM_SRC  one-hot of src_sel while in SHOW; all zero in IDLE.
- disp_valid  out  1  high while in SHOW.

Behaviour:
- Reset, sampled on the clk edge when rst_n=0:
  - state=IDLE, src_sel=0, q_a=16'h0000, grant=0, disp_valid=0, dwell_cnt=0.
  - Reset mid-dwell or mid-advance discards all progress.
- States are IDLE and SHOW.
- IDLE:
  - Outputs q_a=0, disp_valid=0, grant=0.
  - If any src_valid is set, go to SHOW next cycle with src_sel = lowest-index valid source, q_a = that source's data, and dwell_cnt=0.
- SHOW:
  - Every cycle, q_a <= src_data[src_sel]. Data is live, so there is one cycle of latency from a src_data change to q_a.
  - The dwell counter increments only when auto_en=1; it holds its value when auto_en=0.
- Advance event occurs if any of:
  - btn_next=1;
  - auto_en=1 and dwell_cnt==DWELL_CYCLES-1;
  - src_valid[src_sel]==0.
- Next-source pick:
  - Round-robin search from src_sel+1 through src_sel+NUM_SRC, modulo NUM_SRC, so the current source is checked last. Take the first valid index.
  - On advance, next cycle: src_sel <= pick, q_a <= src_data[pick], grant updated, dwell_cnt <= 0.
- Single valid source: the advance re-selects the same index, q_a continues, and dwell_cnt resets to 0.
- No valid source at the advance point, including when the current source drops: go to IDLE next cycle. src_sel holds its last value.
- Simultaneous btn_next and dwell expiry: exactly one advance. Never skip two sources in one cycle.
- btn_next in IDLE: ignored.
- auto_en deasserted mid-dwell: the count freezes and resumes from the same value when auto_en returns to 1.
- Wrap-around: from index NUM_SRC-1 the search continues at 0.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package seg_pkg contains:
  - state encoding constants ST_IDLE=1'b0, ST_SHOW=1'b1;
  - DIGIT_W=4 and DISP_W=16;
  - default NUM_SRC.
- Sub-module seg_rr_pick is combinational.
  - Inputs: valid vector and current index.
  - Outputs: next index and an any_valid flag.
  - It is reused by future display and debug arbiters.

Test Plan (sim with DWELL_CYCLES=4):
1. Reset then src_valid=4'b0000 for 10 cycles -> q_a=0, disp_valid=0, grant=0 throughout. Raise src_valid=4'b0100 with src_data[2]=16'hBEEF -> one cycle later src_sel=2, grant=4'b0100, q_a=16'hBEEF.
2. Auto rotation: src_valid=4'b1011, data 16'h1111/16'h2222/-/16'h4444, auto_en=1 -> src_sel sequence 0,1,3,0, each held exactly 4 cycles. q_a follows 1111, 2222, 4444, 1111.
3. Button and expiry collide: assert btn_next on the cycle dwell_cnt==3 with sel=0 and valid=4'b1111 -> src_sel=1 (not 2), and dwell_cnt=0 the next cycle.
4. Source drop: showing sel=3, deassert src_valid[3] -> next cycle src_sel=0. Then drop all sources -> IDLE, q_a=0, disp_valid=0, src_sel stays 0.
5. Freeze: auto_en=0 at dwell_cnt=2 for 20 cycles -> no advance. Change src_data of the selected source to 16'hCAFE -> q_a=16'hCAFE one cycle later. Re-enable auto_en -> advance after 2 more cycles.
6. Reset mid-SHOW: hold rst_n=0 for one edge while sel=2 -> next cycle all outputs are at reset values. After release, the lowest valid source is re-selected.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter family.
package seg_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned DISP_W          = 16;
  localparam int unsigned SEG_NUM_SRC_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } seg_state_e;

endpackage

// File: rtl/seg_rr_pick.sv
// Round-robin picker: first valid index after cur, wrapping, with cur checked last.
module seg_rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [SEL_W-1:0]   cur,
  output logic [SEL_W-1:0]   nxt,
  output logic               any_valid
);

  // Scan cur+1 .. cur+NUM_SRC modulo NUM_SRC and keep the first hit.
  always_comb begin
    logic                found;
    logic [SEL_W-1:0]    idx_s;
    int unsigned         idx;
    found = 1'b0;
    nxt   = cur;
    idx   = 0;
    idx_s = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx   = (int'(cur) + k) % NUM_SRC;
      idx_s = SEL_W'(idx);
      if (!found && valid[idx_s]) begin
        found = 1'b1;
        nxt   = idx_s;
      end
    end
    any_valid = |valid;
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit hex scanner between several debug sources.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned NUM_SRC      = SEG_NUM_SRC_DEF,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [DISP_W*NUM_SRC-1:0] src_data,
  input  logic                      btn_next,
  input  logic                      auto_en,
  output logic [DISP_W-1:0]         q_a,
  output logic [SEL_W-1:0]          src_sel,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      disp_valid
);

  seg_state_e          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DISP_W-1:0]   q_a_q, q_a_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic                disp_valid_q, disp_valid_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;

  logic [SEL_W-1:0]    pick_cur;
  logic [SEL_W-1:0]    pick;
  logic                any_valid;
  logic                advance;

  // From IDLE, starting the search just below index 0 yields the lowest valid source.
  always_comb begin
    pick_cur = (state_q == ST_IDLE) ? SEL_W'(NUM_SRC - 1) : sel_q;
  end

  seg_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .valid     (src_valid),
    .cur       (pick_cur),
    .nxt       (pick),
    .any_valid (any_valid)
  );

  // Next-state and next-output computation for the IDLE/SHOW arbiter.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    q_a_d        = q_a_q;
    grant_d      = grant_q;
    disp_valid_d = disp_valid_q;
    dwell_d      = dwell_q;
    advance      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        q_a_d        = '0;
        grant_d      = '0;
        disp_valid_d = 1'b0;
        dwell_d      = '0;
        if (any_valid) begin
          state_d      = ST_SHOW;
          sel_d        = pick;
          q_a_d        = src_data[DISP_W*int'(pick) +: DISP_W];
          grant_d      = NUM_SRC'(1) << pick;
          disp_valid_d = 1'b1;
        end
      end
      ST_SHOW: begin
        advance = btn_next
                | (auto_en && (dwell_q == CNT_W'(DWELL_CYCLES - 1)))
                | ~src_valid[sel_q];
        if (advance) begin
          dwell_d = '0;
          if (any_valid) begin
            sel_d   = pick;
            q_a_d   = src_data[DISP_W*int'(pick) +: DISP_W];
            grant_d = NUM_SRC'(1) << pick;
          end else begin
            state_d      = ST_IDLE;
            q_a_d        = '0;
            grant_d      = '0;
            disp_valid_d = 1'b0;
          end
        end else begin
          q_a_d = src_data[DISP_W*int'(sel_q) +: DISP_W];
          if (auto_en) begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      q_a_q        <= '0;
      grant_q      <= '0;
      disp_valid_q <= 1'b0;
      dwell_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      q_a_q        <= q_a_d;
      grant_q      <= grant_d;
      disp_valid_q <= disp_valid_d;
      dwell_q      <= dwell_d;
    end
  end

  assign q_a        = q_a_q;
  assign src_sel    = sel_q;
  assign grant      = grant_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic against a reference model.
module tb_seg_display_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned SW    = 2;
  localparam int unsigned DWELL = 4;
  localparam int unsigned CW    = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  src_valid;
  logic [16*N-1:0] src_data;
  logic          btn_next;
  logic          auto_en;
  logic [15:0]   q_a;
  logic [SW-1:0] src_sel;
  logic [N-1:0]  grant;
  logic          disp_valid;

  int unsigned n_checks;
  int unsigned n_err;

  // reference model state
  bit          m_show;
  int unsigned m_sel;
  int unsigned m_cnt;
  int unsigned m_q;

  seg_display_arbiter #(
    .NUM_SRC      (N),
    .SEL_W        (SW),
    .DWELL_CYCLES (DWELL),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .btn_next   (btn_next),
    .auto_en    (auto_en),
    .q_a        (q_a),
    .src_sel    (src_sel),
    .grant      (grant),
    .disp_valid (disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned data_of(int unsigned i);
    logic [16*N-1:0] d;
    d = src_data;
    return int'(d[16*i +: 16]);
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_step();
    bit adv;
    bit found;
    int unsigned p;
    if (!rst_n) begin
      m_show = 0; m_sel = 0; m_q = 0; m_cnt = 0;
    end else if (!m_show) begin
      m_q = 0;
      if (src_valid != 0) begin
        for (int i = N - 1; i >= 0; i--) if (src_valid[i]) p = i;
        m_show = 1; m_sel = p; m_q = data_of(p); m_cnt = 0;
      end
    end else begin
      adv = btn_next || (auto_en && m_cnt == DWELL - 1) || !src_valid[m_sel];
      if (adv) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && src_valid[(m_sel + k) % N]) begin
            found = 1; p = (m_sel + k) % N;
          end
        end
        m_cnt = 0;
        if (found) begin
          m_sel = p; m_q = data_of(p);
        end else begin
          m_show = 0; m_q = 0;
        end
      end else begin
        m_q = data_of(m_sel);
        if (auto_en) m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("q_a", 32'(q_a), m_q);
    check("src_sel", 32'(src_sel), m_sel);
    check("grant", 32'(grant), m_show ? (32'd1 << m_sel) : 32'd0);
    check("disp_valid", 32'(disp_valid), 32'(m_show));
  endtask

  task automatic set_data(input int unsigned i, input logic [15:0] v);
    src_data[16*i +: 16] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    m_show = 0; m_sel = 0; m_cnt = 0; m_q = 0;
    rst_n = 1'b0; src_valid = '0; src_data = '0; btn_next = 1'b0; auto_en = 1'b0;
    #2;

    // 1: reset, idle with no sources, then single source appears
    tick(); tick();
    check("rst_q_a", 32'(q_a), 32'h0);
    check("rst_dv", 32'(disp_valid), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel", 32'(src_sel), 32'h0);
    rst_n = 1'b1;
    repeat (10) tick();
    set_data(2, 16'hBEEF);
    src_valid = 4'b0100;
    tick();
    check("t1_sel", 32'(src_sel), 32'd2);
    check("t1_grant", 32'(grant), 32'b0100);
    check("t1_q", 32'(q_a), 32'hBEEF);

    // 2: auto rotation 0,1,3,0 each held DWELL cycles
    do_reset();
    set_data(0, 16'h1111); set_data(1, 16'h2222); set_data(2, 16'h3333); set_data(3, 16'h4444);
    src_valid = 4'b1011; auto_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      int unsigned exp_sel;
      tick();
      exp_sel = (t / 4 == 0) ? 0 : (t / 4 == 1) ? 1 : (t / 4 == 2) ? 3 : 0;
      check("t2_seq", 32'(src_sel), exp_sel);
    end

    // 3: button pulse on the same cycle as dwell expiry advances only once
    do_reset();
    src_valid = 4'b1111; auto_en = 1'b1;
    repeat (4) tick();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    check("t3_one_step", 32'(src_sel), 32'd1);
    repeat (3) tick();
    check("t3_cnt_reset", 32'(src_sel), 32'd1);
    tick();
    check("t3_next", 32'(src_sel), 32'd2);

    // 4: current source drops, then all sources drop
    auto_en = 1'b0;
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check("t4_at3", 32'(src_sel), 32'd3);
    src_valid = 4'b0111;
    tick();
    check("t4_drop", 32'(src_sel), 32'd0);
    src_valid = 4'b0000;
    tick();
    check("t4_idle_dv", 32'(disp_valid), 32'd0);
    check("t4_idle_q", 32'(q_a), 32'd0);
    check("t4_idle_sel", 32'(src_sel), 32'd0);
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check("t4_btn_idle", 32'(disp_valid), 32'd0);

    // 5: freeze dwell with auto_en low, live data update, resume
    do_reset();
    src_valid = 4'b0011; auto_en = 1'b1;
    repeat (3) tick();
    auto_en = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      check("t5_frozen", 32'(src_sel), 32'd0);
    end
    set_data(0, 16'hCAFE);
    tick();
    check("t5_live", 32'(q_a), 32'hCAFE);
    auto_en = 1'b1;
    tick();
    check("t5_resume1", 32'(src_sel), 32'd0);
    tick();
    check("t5_resume2", 32'(src_sel), 32'd1);

    // 6: reset while showing source 2
    do_reset();
    src_valid = 4'b1111; auto_en = 1'b0;
    tick();
    btn_next = 1'b1; tick(); tick(); btn_next = 1'b0;
    check("t6_at2", 32'(src_sel), 32'd2);
    rst_n = 1'b0;
    tick();
    check("t6_rst_sel", 32'(src_sel), 32'd0);
    check("t6_rst_dv", 32'(disp_valid), 32'd0);
    check("t6_rst_q", 32'(q_a), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t6_reselect", 32'(src_sel), 32'd0);
    check("t6_dv", 32'(disp_valid), 32'd1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) src_valid = N'($urandom);
      if ($urandom_range(0, 3) == 0) set_data($urandom_range(0, N - 1), 16'($urandom));
      btn_next = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) auto_en = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
